// File: rtl/alu_seq.sv
// Handshaked, registered ALU with an iterative radix-2 divider.
// Single-cycle ops complete at accept; DIV/DIVI take DATA_WIDTH cycles.
package alu_seq_pkg;
    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_ADDI = 5'd2,
        ALU_MUL  = 5'd3,
        ALU_MULI = 5'd4,
        ALU_SLT  = 5'd5,
        ALU_MIN  = 5'd6,
        ALU_SEQ  = 5'd7,
        ALU_SNEZ = 5'd8,
        ALU_BEQZ = 5'd9,
        ALU_ABS  = 5'd10,
        ALU_SLL  = 5'd11,
        ALU_SLLI = 5'd12,
        ALU_JAL  = 5'd13,
        ALU_DIV  = 5'd14,
        ALU_DIVI = 5'd15
    } alu_instruction_t;
endpackage

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  alu_instruction_t      instruction,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  div_by_zero
);
    localparam int SW = $clog2(DATA_WIDTH);

    typedef enum logic {
        IDLE,
        DIVIDE
    } state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  dbz_q, dbz_d;
    logic                  out_valid_q, out_valid_d;

    logic [DATA_WIDTH-1:0] alu_res;
    logic [DATA_WIDTH-1:0] divisor;
    logic [DATA_WIDTH-1:0] pc_ext;
    logic                  is_div;
    logic                  accept;

    logic [DATA_WIDTH:0]   rem_sh;
    logic [DATA_WIDTH:0]   diff;
    logic                  q_bit;
    logic [DATA_WIDTH-1:0] rem_nx;
    logic [DATA_WIDTH-1:0] quo_nx;

    assign in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

    // Single-cycle result and divisor selection for the presented opcode
    always_comb begin
        alu_res = '0;
        is_div  = 1'b0;
        divisor = op2;
        pc_ext  = '0;
        pc_ext[PC_WIDTH-1:0] = pc;
        case (instruction)
            ALU_ADD:  alu_res = op1 + op2;
            ALU_SUB:  alu_res = op1 - op2;
            ALU_ADDI: alu_res = op1 + imm;
            ALU_MUL:  alu_res = op1 * op2;
            ALU_MULI: alu_res = op1 * imm;
            ALU_SLT:  alu_res = DATA_WIDTH'(op1 < op2);
            ALU_MIN:  alu_res = (op1 < op2) ? op1 : op2;
            ALU_SEQ:  alu_res = DATA_WIDTH'(op1 == op2);
            ALU_SNEZ: alu_res = DATA_WIDTH'(op1 != '0);
            ALU_BEQZ: alu_res = DATA_WIDTH'(op1 == '0);
            ALU_ABS:  alu_res = op1[DATA_WIDTH-1] ? (~op1 + 1'b1) : op1;
            ALU_SLL:  alu_res = op1 << op2[SW-1:0];
            ALU_SLLI: alu_res = op1 << imm[SW-1:0];
            ALU_JAL:  alu_res = pc_ext + imm;
            ALU_DIV:  is_div = 1'b1;
            ALU_DIVI: begin
                is_div  = 1'b1;
                divisor = imm;
            end
            default:  alu_res = '0;
        endcase
    end

    // One restoring-division step: shift in next dividend bit, trial subtract
    always_comb begin
        rem_sh = {rem_q, quo_q[DATA_WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        q_bit  = ~diff[DATA_WIDTH];
        rem_nx = q_bit ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
        quo_nx = {quo_q[DATA_WIDTH-2:0], q_bit};
    end

    // Next-state: accept, divide iteration and output register update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        result_d    = result_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q && !out_ready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_div && divisor != '0) begin
                        state_d = DIVIDE;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = op1;
                        dvs_d   = divisor;
                    end else if (is_div) begin
                        result_d    = '1;
                        dbz_d       = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        result_d    = alu_res;
                        dbz_d       = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            DIVIDE: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SW'(DATA_WIDTH - 1)) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    result_d    = quo_nx;
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            result_q    <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            result_q    <= result_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed test-plan cases plus randomized traffic,
// checked every cycle against a cycle-level behavioural model.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    alu_instruction_t instruction;
    logic [W-1:0]     pc;
    logic [W-1:0]     op1;
    logic [W-1:0]     op2;
    logic [W-1:0]     imm;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic             div_by_zero;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    // model state
    bit           m_ov;
    bit           m_dbz;
    logic [W-1:0] m_res;
    logic [W-1:0] m_pend;
    int           m_busy;
    bit           m_acc;

    always #5 clk = ~clk;

    alu_seq #(.DATA_WIDTH(W), .PC_WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instruction(instruction),
        .pc         (pc),
        .op1        (op1),
        .op2        (op2),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .div_by_zero(div_by_zero)
    );

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // {div_by_zero, result} from the opcode rules
    function automatic logic [W:0] ref_op(alu_instruction_t op,
        logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] im, logic [W-1:0] p);
        logic [W-1:0] r;
        logic [W-1:0] d;
        r = '0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_ADDI: r = a + im;
            ALU_MUL:  r = a * b;
            ALU_MULI: r = a * im;
            ALU_SLT:  r = (a < b) ? 1 : 0;
            ALU_MIN:  r = (a < b) ? a : b;
            ALU_SEQ:  r = (a == b) ? 1 : 0;
            ALU_SNEZ: r = (a != 0) ? 1 : 0;
            ALU_BEQZ: r = (a == 0) ? 1 : 0;
            ALU_ABS:  r = a[W-1] ? (0 - a) : a;
            ALU_SLL:  r = a << (b % W);
            ALU_SLLI: r = a << (im % W);
            ALU_JAL:  r = p + im;
            ALU_DIV, ALU_DIVI: begin
                d = (op == ALU_DIV) ? b : im;
                if (d == 0) return {1'b1, {W{1'b1}}};
                r = a / d;
            end
            default:  r = '0;
        endcase
        return {1'b0, r};
    endfunction

    function automatic logic [W-1:0] rv();
        case ($urandom_range(0, 6))
            0: return 0;
            1: return 1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    // cycle-level model, advanced on every rising edge
    initial begin
        logic [W:0] r;
        logic [W-1:0] dv;
        bit acc;
        m_ov = 0; m_dbz = 0; m_res = 0; m_busy = 0; m_acc = 0; m_pend = 0;
        forever begin
            @(posedge clk);
            m_acc = 0;
            if (reset) begin
                m_ov = 0; m_res = 0; m_dbz = 0; m_busy = 0;
            end else begin
                acc = in_valid && m_busy == 0 && (!m_ov || out_ready);
                m_acc = acc;
                if (m_ov && out_ready) m_ov = 0;
                if (m_busy > 0) begin
                    m_busy--;
                    if (m_busy == 0) begin
                        m_res = m_pend; m_dbz = 0; m_ov = 1;
                    end
                end else if (acc) begin
                    dv = (instruction == ALU_DIVI) ? imm : op2;
                    if ((instruction == ALU_DIV || instruction == ALU_DIVI)
                        && dv != 0) begin
                        m_busy = W;
                        m_pend = op1 / dv;
                    end else begin
                        r = ref_op(instruction, op1, op2, imm, pc);
                        m_dbz = r[W];
                        m_res = r[W-1:0];
                        m_ov = 1;
                    end
                end
            end
        end
    end

    // per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("cyc_in_ready", in_ready,
                    (m_busy == 0) && (!m_ov || out_ready));
                chk("cyc_out_valid", out_valid, m_ov);
                chk("cyc_result", result, m_res);
                chk("cyc_dbz", div_by_zero, m_dbz);
            end
        end
    end

    task automatic issue(alu_instruction_t op, logic [W-1:0] a,
        logic [W-1:0] b, logic [W-1:0] im, logic [W-1:0] p);
        int n;
        n = 0;
        instruction = op; op1 = a; op2 = b; imm = im; pc = p;
        in_valid = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!m_acc && n < 200);
        if (!m_acc) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!out_valid) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        int cyc;
        reset = 1; in_valid = 0; out_ready = 1;
        instruction = ALU_ADD; pc = 0; op1 = 0; op2 = 0; imm = 0;
        @(posedge clk); #1;
        started = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_in_ready", in_ready, 1);

        // pin the model with hand-computed values
        chk("pin_sub", ref_op(ALU_SUB, 3, 5, 0, 0), {1'b0, 32'hFFFF_FFFE});
        chk("pin_div", ref_op(ALU_DIV, 100, 7, 0, 0), 14);
        chk("pin_dz", ref_op(ALU_DIV, 9, 0, 0, 0), {1'b1, 32'hFFFF_FFFF});
        chk("pin_abs", ref_op(ALU_ABS, 32'h8000_0000, 0, 0, 0), 32'h8000_0000);
        chk("pin_sll", ref_op(ALU_SLL, 1, 33, 0, 0), 2);

        issue(ALU_ADD, 5, 7, 0, 0);
        chk("add_valid", out_valid, 1);
        chk("add", result, 12);
        issue(ALU_SUB, 3, 5, 0, 0);
        chk("sub", result, 32'hFFFF_FFFE);
        issue(ALU_MUL, 32'h10000, 32'h10000, 0, 0);
        chk("mul", result, 0);

        issue(ALU_DIV, 100, 7, 0, 0);
        chk("div_busy", in_ready, 0);
        wait_valid(cyc);
        chk("div_latency", cyc, 32);
        chk("div", result, 14);
        chk("div_dbz", div_by_zero, 0);
        issue(ALU_DIVI, 32'hFFFF_FFFF, 0, 1, 0);
        wait_valid(cyc);
        chk("divi", result, 32'hFFFF_FFFF);

        issue(ALU_DIV, 9, 0, 0, 0);
        chk("dz_valid", out_valid, 1);
        chk("dz_result", result, 32'hFFFF_FFFF);
        chk("dz_flag", div_by_zero, 1);
        issue(ALU_ADD, 1, 1, 0, 0);
        chk("add2", result, 2);
        chk("add2_dbz", div_by_zero, 0);

        issue(ALU_SLL, 1, 33, 0, 0);
        chk("sll_mask", result, 2);
        issue(ALU_ABS, 32'h8000_0000, 0, 0, 0);
        chk("abs_min", result, 32'h8000_0000);
        issue(ALU_MIN, 32'hFFFF_FFFF, 1, 0, 0);
        chk("min", result, 1);
        issue(ALU_JAL, 0, 0, 32'h20, 32'h100);
        chk("jal", result, 32'h120);
        issue(ALU_BEQZ, 0, 0, 0, 0);
        chk("beqz", result, 1);

        issue(ALU_ADD, 2, 2, 0, 0);
        out_ready = 0;
        instruction = ALU_SEQ; op1 = 3; op2 = 3;
        in_valid = 1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_result", result, 4);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1;
        #1 chk("bp_release", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        chk("bp_accept", m_acc, 1);
        chk("seq", result, 1);

        issue(ALU_DIV, 1000, 3, 0, 0);
        repeat (9) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("abort_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_ready", in_ready, 1);
        issue(ALU_ADD, 1, 2, 0, 0);
        chk("after_abort", result, 3);

        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom % 4) != 0;
            if (!in_valid && ($urandom % 3) != 0) begin
                instruction = alu_instruction_t'($urandom_range(0, 19));
                op1 = rv(); op2 = rv(); imm = rv(); pc = $urandom;
                in_valid = 1;
            end
            @(posedge clk); #1;
            if (m_acc) in_valid = 0;
        end
        in_valid = 0;
        out_ready = 1;
        repeat (40) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
